dmem_arbiter: RTL and testbench

- Two-port arbiter that shares the single-port data memory between requester A (CPU load/store unit) and requester B (debug/loader port).
- Serialises accesses through the memory's shared address, write-data, write-enable and read-enable signals.
- Returns registered read data plus a one-cycle ack to the winning requester.
- Sits between the requesters and the data memory instance; the memory itself is not modified.

---
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory: IDLE -> ACCESS -> RESP, one access per 3 cycles.
// Tie-break is round-robin unless DMEM_ARB_FIXED_PRIO_EN is defined, in which case A always wins.
module dmem_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  state_t            state, state_nxt;
  logic              lat_we;
  logic              lat_port;   // 0 = A, 1 = B
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              grant_any;
  logic              grant_b;
  logic              in_range;

  assign grant_any = a_req | b_req;
  assign in_range  = (lat_addr < DEPTH_A);

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign grant_b = b_req & ~a_req;
`else
  logic pref_b;  // 1 when B should win the next tie

  assign grant_b = b_req & (~a_req | pref_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pref_b <= 1'b0;
    end else if (state == IDLE && grant_any) begin
      pref_b <= ~grant_b;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;
    a_ack           = 1'b0;
    a_rdata         = '0;
    a_err           = 1'b0;
    b_ack           = 1'b0;
    b_rdata         = '0;
    b_err           = 1'b0;
    busy            = (state != IDLE);
    case (state)
      ACCESS: begin
        mem_access_addr = lat_addr;
        mem_write_data  = lat_wdata;
        mem_write_en    = lat_we & in_range;
        mem_read        = ~lat_we & in_range;
      end
      RESP: begin
        if (lat_port) begin
          b_ack   = 1'b1;
          b_rdata = rdata_q;
          b_err   = err_q;
        end else begin
          a_ack   = 1'b1;
          a_rdata = rdata_q;
          a_err   = err_q;
        end
      end
      default: ;
    endcase
  end

  // Request latch in IDLE, response capture on the edge that ends ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we    <= 1'b0;
      lat_port  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state == IDLE && grant_any) begin
        lat_port  <= grant_b;
        lat_we    <= grant_b ? b_we    : a_we;
        lat_addr  <= grant_b ? b_addr  : a_addr;
        lat_wdata <= grant_b ? b_wdata : a_wdata;
      end
      if (state == ACCESS) begin
        rdata_q <= (!lat_we && in_range) ? mem_read_data : '0;
        err_q   <= ~in_range;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 8-word memory and an ack scoreboard.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [15:0] a_addr = '0, a_wdata = '0;
  logic        a_ack, a_err;
  logic [15:0] a_rdata;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [15:0] b_addr = '0, b_wdata = '0;
  logic        b_ack, b_err;
  logic [15:0] b_rdata;
  logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read, busy;

  typedef struct packed {
    logic        port;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [15:0] tbmem [0:7];
  logic [15:0] ref_mem [0:7];
  logic        mem_load = 1'b1;
  int          wr_cnt = 0;
  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(16), .ADDR_W(16), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read),
    .mem_read_data(mem_read_data), .busy(busy)
  );

  // Memory model: wraps on 3 address bits, so a leaked out-of-range write lands in a real word.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 8; i++) tbmem[i] <= 16'hA000 + 16'(i);
    end else if (mem_write_en) begin
      tbmem[mem_access_addr[2:0]] <= mem_write_data;
    end
    if (mem_write_en) wr_cnt <= wr_cnt + 1;
  end

  assign mem_read_data = mem_read ? tbmem[mem_access_addr[2:0]] : 16'hDEAD;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (a_ack || b_ack)) begin
      check("ack_exclusive", {31'd0, a_ack & b_ack}, 32'd0);
      if (q.size() == 0) begin
        check("unexpected_ack", {30'd0, b_ack, a_ack}, 32'd0);
      end else begin
        mon_e = q.pop_front();
        check("ack_port", {31'd0, b_ack}, {31'd0, mon_e.port});
        check("rdata", {16'd0, mon_e.port ? b_rdata : a_rdata}, {16'd0, mon_e.rdata});
        check("err", {31'd0, mon_e.port ? b_err : a_err}, {31'd0, mon_e.err});
        check("idle_port_quiet", {15'd0, mon_e.port ? {a_err, a_rdata} : {b_err, b_rdata}}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic expect_ack(input logic port, input logic we, input logic [15:0] addr);
    exp_t e;
    e.port  = port;
    e.err   = (addr >= 16'd8);
    e.rdata = (we || addr >= 16'd8) ? 16'h0 : ref_mem[addr[2:0]];
    q.push_back(e);
  endtask

  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [15:0] addr, input logic [15:0] wdata);
    if (port) begin
      b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
    end
  endtask

  task automatic access(input logic port, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    int  n;
    logic seen;
    expect_ack(port, we, addr);
    if (we && addr < 16'd8) ref_mem[addr[2:0]] = wdata;
    drive(port, 1'b1, we, addr, wdata);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      tick();
      n++;
      seen = port ? b_ack : a_ack;
    end
    check("ack_seen", {31'd0, seen}, 32'd1);
    check("ack_latency", n, 32'd2);
    drive(port, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acks;
    int busy_n;
    int wr0;
    for (int i = 0; i < 8; i++) ref_mem[i] = 16'hA000 + 16'(i);

    // Reset state
    #2;
    check("reset_outputs", {25'd0, a_ack, b_ack, a_err, b_err, mem_write_en, mem_read, busy}, 32'd0);
    check("reset_data", {a_rdata, b_rdata}, 32'd0);
    check("reset_mem_bus", {mem_access_addr, mem_write_data}, 32'd0);
    do_reset();
    mem_load = 1'b0;

    // 1: A writes 3 <- BEEF, then reads it back
    expect_ack(1'b0, 1'b1, 16'd3);
    ref_mem[3] = 16'hBEEF;
    drive(1'b0, 1'b1, 1'b1, 16'd3, 16'hBEEF);
    tick();
    check("t1_wen", {31'd0, mem_write_en}, 32'd1);
    check("t1_addr", {16'd0, mem_access_addr}, 32'd3);
    check("t1_wdata", {16'd0, mem_write_data}, 32'h0000BEEF);
    check("t1_no_early_ack", {31'd0, a_ack}, 32'd0);
    tick();
    check("t1_wen_one_cycle", {31'd0, mem_write_en}, 32'd0);
    check("t1_ack", {30'd0, a_ack, a_err}, 32'd2);
    drive(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    tick();
    check("t1_idle", {31'd0, busy}, 32'd0);
    access(1'b0, 1'b0, 16'd3, 16'h0);

    // 2: both read continuously from reset
    do_reset();
`ifdef DMEM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) expect_ack(1'b0, 1'b0, 16'd0);
`else
    for (int k = 0; k < 2; k++) begin
      expect_ack(1'b0, 1'b0, 16'd0);
      expect_ack(1'b1, 1'b0, 16'd1);
    end
`endif
    drive(1'b0, 1'b1, 1'b0, 16'd0, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 16'd1, 16'h0);
    for (int c = 1; c <= 12; c++) begin
      tick();
`ifdef DMEM_ARB_FIXED_PRIO_EN
      check($sformatf("t2_a_ack_c%0d", c), {31'd0, a_ack}, {31'd0, c % 3 == 2});
      check($sformatf("t2_b_ack_c%0d", c), {31'd0, b_ack}, 32'd0);
`else
      check($sformatf("t2_a_ack_c%0d", c), {31'd0, a_ack}, {31'd0, (c == 2 || c == 8)});
      check($sformatf("t2_b_ack_c%0d", c), {31'd0, b_ack}, {31'd0, (c == 5 || c == 11)});
`endif
    end
    drive(1'b0, 1'b0, 1'b0, 16'd0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'd0, 16'h0);
    tick();

    // 3: out-of-range write from B must not reach memory
    wr0 = wr_cnt;
    access(1'b1, 1'b1, 16'd9, 16'h5555);
    check("t3_no_write", wr_cnt, wr0);
    access(1'b0, 1'b0, 16'd1, 16'h0);

    // 4: reset during ACCESS of a write
    wr0 = wr_cnt;
    drive(1'b0, 1'b1, 1'b1, 16'd5, 16'h1234);
    tick();
    check("t4_in_access", {31'd0, mem_write_en}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t4_outputs_cleared", {25'd0, a_ack, b_ack, a_err, b_err, mem_write_en, mem_read, busy}, 32'd0);
    check("t4_bus_cleared", {mem_access_addr, mem_write_data}, 32'd0);
    check("t4_rdata_cleared", {a_rdata, b_rdata}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 16'd0, 16'h0);
    tick();
    tick();
    rst_n = 1'b1;
    check("t4_write_dropped", wr_cnt, wr0);
    access(1'b0, 1'b0, 16'd5, 16'h0);

    // 5: one access per held request window; changes after latching are ignored
    wr0 = wr_cnt;
    expect_ack(1'b0, 1'b0, 16'd2);
    drive(1'b0, 1'b1, 1'b0, 16'd2, 16'h0);
    acks = 0;
    busy_n = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      acks += int'(a_ack);
      busy_n += int'(busy);
      if (c == 1) drive(1'b0, 1'b1, 1'b1, 16'd7, 16'hFFFF);
      if (c == 3) drive(1'b0, 1'b0, 1'b0, 16'd0, 16'h0);
    end
    check("t5_one_ack", acks, 32'd1);
    check("t5_busy_cycles", busy_n, 32'd2);
    check("t5_latched_no_write", wr_cnt, wr0);
    expect_ack(1'b0, 1'b0, 16'd3);
    expect_ack(1'b0, 1'b0, 16'd3);
    drive(1'b0, 1'b1, 1'b0, 16'd3, 16'h0);
    acks = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      acks += int'(a_ack);
      if (c == 5) begin
        check("t5_second_ack", {31'd0, a_ack}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 16'd0, 16'h0);
      end
    end
    check("t5_two_acks", acks, 32'd2);

    // 6: B arrives while A is in ACCESS
    expect_ack(1'b0, 1'b0, 16'd4);
    expect_ack(1'b1, 1'b0, 16'd6);
    drive(1'b0, 1'b1, 1'b0, 16'd4, 16'h0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) drive(1'b1, 1'b1, 1'b0, 16'd6, 16'h0);
      if (c == 3) drive(1'b0, 1'b0, 1'b0, 16'd0, 16'h0);
      if (c >= 3) check($sformatf("t6_b_ack_c%0d", c), {31'd0, b_ack}, {31'd0, c == 5});
    end
    drive(1'b1, 1'b0, 1'b0, 16'd0, 16'h0);
    tick();
    tick();

    check("sb_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
